// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the multicycle sequencer: opcodes, FSM states,
// ALU/PC select codes and the static per-opcode control bundle.
package multicycle_sequencer_pkg;

  localparam logic [2:0] OP_R    = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_ILL  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Static controls that depend only on the latched opcode.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       uses_mem;
    logic       is_store;
    logic       uses_wb;
    logic       is_branch;
  } ctrl_t;

endpackage

// File: rtl/multicycle_sequencer_opcode_decoder.sv
// Combinational per-opcode control lookup; no state.
module opcode_decoder
  import multicycle_sequencer_pkg::*;
(
  input  logic [2:0] opcode,
  output ctrl_t      ctrl
);

  // Map each opcode to its static datapath controls and path through the FSM.
  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_R: begin
        ctrl.alu_op  = ALU_FUNCT;
        ctrl.reg_dst = 1'b1;
        ctrl.uses_wb = 1'b1;
      end
      OP_ADDI: begin
        ctrl.alu_op  = ALU_ADD;
        ctrl.alu_src = 1'b1;
        ctrl.uses_wb = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_op     = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.uses_mem   = 1'b1;
        ctrl.uses_wb    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_op   = ALU_ADD;
        ctrl.alu_src  = 1'b1;
        ctrl.uses_mem = 1'b1;
        ctrl.is_store = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op    = ALU_SUB;
        ctrl.is_branch = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: FSM, opcode latch and retired counter.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_FETCH  | imem_req held; on imem_ack load IR and PC+1
// ST_DECODE | latch opcode; JMP finishes here, 110/111 go to ST_HALT
// ST_EXEC   | ALU op from latched opcode; BEQ finishes here
// ST_MEM    | dmem_req held with read/write until dmem_ack
// ST_WB     | one-cycle register write, then fetch
// ST_HALT   | absorbing; only reset leaves it
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  // Low for the first cycle after reset so imem_req appears on the first edge.
  logic             active_q;
  logic             cnt_inc;
  ctrl_t            ctrl;

  opcode_decoder u_dec (
    .opcode (opcode_q),
    .ctrl   (ctrl)
  );

  // Next state, opcode latch, illegal flag and retire strobe.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    cnt_inc   = 1'b0;
    if (active_q) begin
      case (state_q)
        ST_FETCH: if (imem_ack) state_d = ST_DECODE;
        ST_DECODE: begin
          opcode_d = opcode;
          case (opcode)
            OP_JMP: begin
              state_d = ST_FETCH;
              cnt_inc = 1'b1;
            end
            OP_ILL: begin
              state_d   = ST_HALT;
              illegal_d = 1'b1;
            end
            OP_HALT: state_d = ST_HALT;
            default: state_d = ST_EXEC;
          endcase
        end
        ST_EXEC: begin
          if (ctrl.uses_mem) begin
            state_d = ST_MEM;
          end else if (ctrl.uses_wb) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            cnt_inc = 1'b1;
          end
        end
        ST_MEM: begin
          if (dmem_ack) begin
            if (ctrl.is_store) begin
              state_d = ST_FETCH;
              cnt_inc = 1'b1;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          state_d = ST_FETCH;
          cnt_inc = 1'b1;
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_FETCH;
      endcase
    end
    cnt_d = cnt_inc ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // State and bookkeeping registers; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= OP_R;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      active_q  <= 1'b1;
    end
  end

  // Strobes from registered state; only DECODE looks at the live opcode.
  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_INC;
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    if (active_q) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_INC;
          end
        end
        ST_DECODE: begin
          if (opcode == OP_JMP) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
        end
        ST_EXEC: begin
          alu_op  = ctrl.alu_op;
          alu_src = ctrl.alu_src;
          if (ctrl.is_branch) begin
            pc_write = zero;
            pc_src   = PC_BRANCH;
          end
        end
        ST_MEM: begin
          dmem_req  = 1'b1;
          mem_read  = !ctrl.is_store;
          mem_write = ctrl.is_store;
        end
        ST_WB: begin
          reg_write  = 1'b1;
          reg_dst    = ctrl.reg_dst;
          mem_to_reg = ctrl.mem_to_reg;
        end
        ST_HALT: halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  assign illegal     = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with hand-written per-cycle vectors.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       halted;
    logic       illegal;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] opcode = 3'b000;
  logic zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;

  logic imem_req, dmem_req, ir_write, pc_write, reg_dst, alu_src, mem_to_reg;
  logic reg_write, mem_read, mem_write, halted, illegal;
  logic [1:0] pc_src, alu_op;
  logic [15:0] instr_count;

  logic imem_req4, dmem_req4, ir_write4, pc_write4, reg_dst4, alu_src4, mem_to_reg4;
  logic reg_write4, mem_read4, mem_write4, halted4, illegal4;
  logic [1:0] pc_src4, alu_op4;
  logic [3:0] cnt4;

  outs_t obs;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_dst(reg_dst),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_op(alu_op),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  multicycle_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req4), .dmem_req(dmem_req4), .ir_write(ir_write4),
    .pc_write(pc_write4), .pc_src(pc_src4), .reg_dst(reg_dst4),
    .alu_src(alu_src4), .mem_to_reg(mem_to_reg4), .reg_write(reg_write4),
    .mem_read(mem_read4), .mem_write(mem_write4), .alu_op(alu_op4),
    .halted(halted4), .illegal(illegal4), .instr_count(cnt4)
  );

  assign obs = '{imem_req, dmem_req, ir_write, pc_write, pc_src, alu_op,
                 alu_src, reg_dst, mem_to_reg, reg_write, mem_read, mem_write,
                 halted, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs at step j of an instruction with no memory wait states.
  function automatic outs_t golden(input logic [2:0] op, input int j, input logic z);
    outs_t g;
    g = '0;
    case (j)
      0: begin g.imem_req = 1; g.ir_write = 1; g.pc_write = 1; end
      1: if (op == OP_JMP) begin g.pc_write = 1; g.pc_src = 2'b10; end
      2: case (op)
           OP_R:   g.alu_op = 2'b10;
           OP_BEQ: begin g.alu_op = 2'b01; g.pc_src = 2'b01; g.pc_write = z; end
           default: g.alu_src = 1;
         endcase
      3: case (op)
           OP_R:    begin g.reg_write = 1; g.reg_dst = 1; end
           OP_ADDI: g.reg_write = 1;
           OP_LW:   begin g.dmem_req = 1; g.mem_read = 1; end
           OP_SW:   begin g.dmem_req = 1; g.mem_write = 1; end
           default: g = '0;
         endcase
      4: if (op == OP_LW) begin g.reg_write = 1; g.mem_to_reg = 1; end
      default: g = '0;
    endcase
    return g;
  endfunction

  // Runs one instruction from FETCH; iw fetch wait cycles, dw memory wait cycles.
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input int iw, input int dw, input int exp_cyc);
    logic [15:0] c0;
    outs_t e;
    int cyc, j, jj;
    bit done, mem_op;
    c0 = instr_count;
    cyc = 0;
    done = 0;
    mem_op = (op == OP_LW) || (op == OP_SW);
    opcode = op;
    zero = z;
    while (!done && cyc < 40) begin
      j = cyc - iw;
      imem_ack = (cyc >= iw);
      dmem_ack = !(mem_op && j >= 3 && j < 3 + dw);
      if (mem_op && j > 3) jj = (j <= 3 + dw) ? 3 : j - dw;
      else jj = j;
      if (j < 0) begin
        e = '0;
        e.imem_req = 1;
      end else begin
        e = golden(op, jj, z);
      end
      @(negedge clk);
      chk($sformatf("%s c%0d", name, cyc), 32'(obs), 32'(e));
      cyc++;
      @(posedge clk);
      #1;
      if (instr_count != c0) done = 1;
    end
    chk($sformatf("%s cycles", name), 32'(cyc), 32'(exp_cyc));
    chk($sformatf("%s count", name), 32'(instr_count), 32'(c0 + 16'd1));
  endtask

  task automatic rst_release();
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("imem_req before first edge", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1 chk("imem_req after first edge", 32'(imem_req), 32'd1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #2;
    chk("reset outputs", 32'(obs), 32'd0);
    chk("reset count", 32'(instr_count), 32'd0);
    chk("reset count4", 32'(cnt4), 32'd0);
    @(posedge clk);
    #1 chk("reset held outputs", 32'(obs), 32'd0);
    rst_release();
  endtask

  // Drives a HALT-class opcode through fetch and decode, then checks absorption.
  task automatic run_halt(input string name, input logic [2:0] op, input logic ill);
    outs_t e;
    logic [15:0] c0;
    c0 = instr_count;
    opcode = op;
    imem_ack = 1;
    dmem_ack = 1;
    @(negedge clk);
    chk({name, " fetch"}, 32'(obs), 32'(golden(op, 0, 1'b0)));
    @(posedge clk); #1;
    @(negedge clk);
    chk({name, " decode"}, 32'(obs), 32'd0);
    e = '0;
    e.halted = 1;
    e.illegal = ill;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      imem_ack = k[0];
      dmem_ack = !k[0];
      opcode = OP_R;
      @(negedge clk);
      chk($sformatf("%s hold%0d", name, k), 32'(obs), 32'(e));
    end
    chk({name, " count frozen"}, 32'(instr_count), 32'(c0));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1;
    reset_dut();

    imem_ack = 1;
    dmem_ack = 1;
    run_instr("R",     OP_R,    1'b0, 0, 0, 4);
    run_instr("ADDI",  OP_ADDI, 1'b0, 0, 0, 4);
    run_instr("LW",    OP_LW,   1'b0, 0, 0, 5);
    run_instr("SW",    OP_SW,   1'b0, 0, 0, 4);
    run_instr("BEQ1",  OP_BEQ,  1'b1, 0, 0, 3);
    run_instr("JMP",   OP_JMP,  1'b0, 0, 0, 2);
    chk("program count", 32'(instr_count), 32'd6);

    run_instr("R_iwait3",  OP_R,   1'b0, 3, 0, 7);
    run_instr("LW_dwait2", OP_LW,  1'b0, 0, 2, 7);
    run_instr("BEQ0",      OP_BEQ, 1'b0, 0, 0, 3);
    chk("after directed count", 32'(instr_count), 32'd9);

    reset_dut();
    for (int i = 0; i < 15; i++) run_instr("Rwrap", OP_R, 1'b0, 0, 0, 4);
    chk("cnt4 at 15", 32'(cnt4), 32'd15);
    run_instr("Rwrap16", OP_R, 1'b0, 0, 0, 4);
    chk("cnt4 wrapped", 32'(cnt4), 32'd0);
    chk("cnt16 at 16", 32'(instr_count), 32'd16);

    // Reset while SW is stalled in MEM.
    opcode = OP_SW;
    imem_ack = 1;
    dmem_ack = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("SWrst c%0d", k), 32'(obs), 32'(golden(OP_SW, k, 1'b0)));
      if (k < 3) begin @(posedge clk); #1; end
    end
    #1 rst_n = 1'b0;
    #1 chk("SWrst mem_write drop", 32'(mem_write), 32'd0);
    chk("SWrst outputs", 32'(obs), 32'd0);
    dmem_ack = 1;
    @(posedge clk);
    #1 chk("SWrst no reg_write", 32'(obs), 32'd0);
    chk("SWrst count", 32'(instr_count), 32'd0);
    rst_release();

    run_halt("ILL", OP_ILL, 1'b1);
    reset_dut();
    chk("illegal cleared", 32'(illegal), 32'd0);
    run_halt("HALT", OP_HALT, 1'b0);
    reset_dut();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
